// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer that shares one combinational float_adder between two
// valid/ready requesters and returns each result on the winner's response channel.
module fp_add_arbiter #(
  parameter int ADD_LAT = 1,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_out,
  output logic         resp0_valid,
  output logic [W-1:0] resp0_data,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  output logic [W-1:0] resp1_data,
  input  logic         resp1_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state, state_nxt;
  logic         owner, last_grant, grant, accept, resp_hs;
  logic [3:0]   cnt;
  logic [W-1:0] result;

  // grant = 0 selects requester 0, 1 selects requester 1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant = 1'b0;
    case ({req1_valid, req0_valid})
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign accept  = (state == IDLE) && (req0_valid || req1_valid);
  assign resp_hs = owner ? resp1_ready : resp0_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a      <= '0;
      add_b      <= '0;
      result     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          add_a <= grant ? req1_a : req0_a;
          add_b <= grant ? req1_b : req0_b;
          owner <= grant;
          cnt   <= 4'(ADD_LAT - 1);
        end
        WAIT: begin
          if (cnt == 4'd0) result <= add_out;
          else             cnt    <= cnt - 4'd1;
        end
        RESP: if (resp_hs) last_grant <= owner;
        default: ;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is asserted.
  always_comb begin
    req0_ready  = !rst && (state == IDLE) && req0_valid && !grant;
    req1_ready  = !rst && (state == IDLE) && req1_valid && grant;
    resp0_valid = !rst && (state == RESP) && !owner;
    resp1_valid = !rst && (state == RESP) && owner;
    resp0_data  = result;
    resp1_data  = result;
    busy        = !rst && (state != IDLE);
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: an ADD_LAT=1 instance driven by a small float adder
// model with a scoreboard, and an ADD_LAT=3 instance for settle-time and reset cases.
module tb_fp_add_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ADD_LAT = 1 instance
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, add_a, add_b, add_out;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready, busy;
  logic [31:0] resp0_data, resp1_data;

  // ADD_LAT = 3 instance
  logic        s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
  logic [31:0] s_req0_a, s_req0_b, s_req1_a, s_req1_b, s_add_a, s_add_b, s_add_out;
  logic        s_resp0_valid, s_resp0_ready, s_resp1_valid, s_resp1_ready, s_busy;
  logic [31:0] s_resp0_data, s_resp1_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Positive-normal single-precision add with truncation; enough for this stimulus.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [24:0] ma, mb, s;
    logic [7:0]  e;
    int          d;
    if (x[30:0] >= y[30:0]) begin a = x; b = y; end
    else begin a = y; b = x; end
    if (b[30:0] == 31'd0) return a;
    d  = int'(a[30:23]) - int'(b[30:23]);
    ma = {2'b01, a[22:0]};
    mb = (d > 24) ? 25'd0 : ({2'b01, b[22:0]} >> d);
    s  = ma + mb;
    e  = a[30:23];
    if (s[24]) begin s = s >> 1; e = e + 8'd1; end
    return {1'b0, e, s[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    return {1'b0, 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
  endfunction

  assign add_out = fadd(add_a, add_b);

  fp_add_arbiter #(.ADD_LAT(1), .W(32)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ready(resp1_ready),
    .busy(busy)
  );

  fp_add_arbiter #(.ADD_LAT(3), .W(32)) u_dut_slow (
    .clk(clk), .rst(rst),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b),
    .add_a(s_add_a), .add_b(s_add_b), .add_out(s_add_out),
    .resp0_valid(s_resp0_valid), .resp0_data(s_resp0_data), .resp0_ready(s_resp0_ready),
    .resp1_valid(s_resp1_valid), .resp1_data(s_resp1_data), .resp1_ready(s_resp1_ready),
    .busy(s_busy)
  );

  // Scoreboard state for the ADD_LAT = 1 instance.
  logic [31:0] exp_q0[$], exp_q1[$];
  int          grant_log[$];
  logic [31:0] op_a = '0, op_b = '0;
  int          acc_cyc = 0;
  logic        prev_rv = 1'b0;
  logic [31:0] last_resp0 = '0, last_resp1 = '0;
  int          resp_cnt0 = 0, resp_cnt1 = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    logic [31:0] exp;
    @(negedge clk);
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      prev_rv = 1'b0;
    end else begin
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL both_ready: req0_ready=%b req1_ready=%b, required at most one", req0_ready, req1_ready);
      end
      if (busy) begin
        checks++;
        if (add_a !== op_a || add_b !== op_b) begin
          errors++;
          $display("FAIL operand_hold: add_a=%h add_b=%h, required %h %h", add_a, add_b, op_a, op_b);
        end
      end
      if ((resp0_valid || resp1_valid) && !prev_rv) begin
        checks++;
        if (cyc - acc_cyc != 2) begin
          errors++;
          $display("FAIL latency: resp after %0d cycles, required 2", cyc - acc_cyc);
        end
      end
      prev_rv = resp0_valid || resp1_valid;
      if (resp0_valid && resp0_ready) begin
        checks++;
        if (exp_q0.size() == 0) begin
          errors++;
          $display("FAIL resp0_unexpected: data=%h, required no response", resp0_data);
        end else begin
          exp = exp_q0.pop_front();
          if (resp0_data !== exp) begin
            errors++;
            $display("FAIL resp0_data: got %h, required %h", resp0_data, exp);
          end
        end
        last_resp0 = resp0_data;
        resp_cnt0++;
      end
      if (resp1_valid && resp1_ready) begin
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $display("FAIL resp1_unexpected: data=%h, required no response", resp1_data);
        end else begin
          exp = exp_q1.pop_front();
          if (resp1_data !== exp) begin
            errors++;
            $display("FAIL resp1_data: got %h, required %h", resp1_data, exp);
          end
        end
        last_resp1 = resp1_data;
        resp_cnt1++;
      end
      if (req0_valid && req0_ready) begin
        exp_q0.push_back(fadd(req0_a, req0_b));
        grant_log.push_back(0);
        op_a = req0_a; op_b = req0_b; acc_cyc = cyc;
      end
      if (req1_valid && req1_ready) begin
        exp_q1.push_back(fadd(req1_a, req1_b));
        grant_log.push_back(1);
        op_a = req1_a; op_b = req1_b; acc_cyc = cyc;
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && exp_q0.size() == 0 && exp_q1.size() == 0) begin done = 1'b1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b pending=%0d, required idle and empty", busy, exp_q0.size() + exp_q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    s_req0_valid = 1'b1; s_req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy0,rdy1,rv0,rv1,busy=%b, required 00000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, busy});
    end
    checks++;
    if ({add_a, add_b, s_add_a, s_add_b} !== 128'd0) begin
      errors++;
      $display("FAIL reset_operands: add_a=%h add_b=%h s_add_a=%h s_add_b=%h, required 0", add_a, add_b, s_add_a, s_add_b);
    end
    checks++;
    if ({s_req0_ready, s_req1_ready, s_busy} !== 3'b0) begin
      errors++;
      $display("FAIL reset_slow_outputs: %b, required 000", {s_req0_ready, s_req1_ready, s_busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; s_req0_valid = 1'b0; s_req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b req0_ready=%b, required 0 0", busy, req0_ready);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000; req0_valid = 1'b1; resp0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: req0_ready=%b busy=%b, required 1 0", req0_ready, busy);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || resp0_valid !== 1'b0 || add_a !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL single_wait: busy=%b resp0_valid=%b add_a=%h, required 1 0 3f800000", busy, resp0_valid, add_a);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || resp0_valid !== 1'b1 || resp0_data !== 32'h4000_0000) begin
      errors++;
      $display("FAIL single_resp: busy=%b resp0_valid=%b data=%h, required 1 1 40000000", busy, resp0_valid, resp0_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b resp0_valid=%b, required 0 0", busy, resp0_valid);
    end
  endtask

  task automatic test_simultaneous();
    int  n0, n1;
    bit  a0, a1, done;
    pulse_reset();
    grant_log.delete();
    n0 = resp_cnt0; n1 = resp_cnt1; done = 1'b0;
    req0_a = 32'h4000_0000; req0_b = 32'h3F80_0000;
    req1_a = 32'h3FC0_0000; req1_b = 32'h3FC0_0000;
    req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      if (resp_cnt0 > n0 && resp_cnt1 > n1) begin done = 1'b1; break; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (!done || grant_log.size() != 2) begin
      errors++;
      $display("FAIL simul_complete: done=%b grants=%0d, required 1 2", done, grant_log.size());
    end else begin
      checks++;
      if (grant_log[0] != 0 || grant_log[1] != 1) begin
        errors++;
        $display("FAIL simul_order: %0d,%0d, required 0,1", grant_log[0], grant_log[1]);
      end
    end
    checks++;
    if (last_resp0 !== 32'h4040_0000 || last_resp1 !== 32'h4040_0000) begin
      errors++;
      $display("FAIL simul_data: resp0=%h resp1=%h, required 40400000 40400000", last_resp0, last_resp1);
    end
    drain();
  endtask

  task automatic test_round_robin();
    bit          a0, a1;
    logic [3:0]  order;
    pulse_reset();
    grant_log.delete();
    req0_a = rand_op(); req0_b = rand_op(); req1_a = rand_op(); req1_b = rand_op();
    req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) begin req0_a = rand_op(); req0_b = rand_op(); end
      if (a1) begin req1_a = rand_op(); req1_b = rand_op(); end
      if (grant_log.size() >= 4) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b1 & 1'b0;
    drain();
    checks++;
    if (grant_log.size() != 4) begin
      errors++;
      $display("FAIL rr_count: %0d grants, required 4", grant_log.size());
    end else begin
      order = {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]};
      checks++;
      if (order !== 4'b0101) begin
        errors++;
        $display("FAIL rr_order: %b, required 0101", order);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit          seen = 1'b0;
    @(posedge clk); #1;
    req1_a = 32'h3F80_0000; req1_b = 32'h4000_0000;
    req1_valid = 1'b1; resp1_ready = 1'b0; resp0_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp1_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      if (busy) begin
        req1_valid = 1'b0;
        req0_a = 32'h4040_0000; req0_b = 32'h3F80_0000; req0_valid = 1'b1;
      end
    end
    held = resp1_data;
    checks++;
    if (!seen || held !== 32'h4040_0000) begin
      errors++;
      $display("FAIL bp_resp: seen=%b data=%h, required 1 40400000", seen, held);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp1_valid !== 1'b1 || resp1_data !== held || req0_ready !== 1'b0 || busy !== 1'b1 || resp0_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: rv1=%b data=%h rdy0=%b busy=%b rv0=%b, required 1 %h 0 1 0",
                 resp1_valid, resp1_data, req0_ready, busy, resp0_valid, held);
      end
    end
    @(posedge clk); #1 resp1_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 resp1_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: busy=%b rv1=%b rdy0=%b, required 0 0 1", busy, resp1_valid, req0_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    drain();
    checks++;
    if (last_resp0 !== 32'h4080_0000) begin
      errors++;
      $display("FAIL bp_followup: resp0=%h, required 40800000", last_resp0);
    end
  endtask

  task automatic test_add_lat3();
    @(posedge clk); #1;
    s_req0_a = 32'h4100_0000; s_req0_b = 32'h3F80_0000; s_req0_valid = 1'b1;
    s_resp0_ready = 1'b1; s_add_out = 32'h4120_0000;
    @(negedge clk);
    checks++;
    if (s_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat3_accept: s_req0_ready=%b, required 1", s_req0_ready);
    end
    // Iteration k drives the add_out value present at the k-th edge after accept.
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      s_req0_valid = 1'b0;
      s_add_out = 32'h4120_0000 + 32'(k * 16);
      @(negedge clk);
      checks++;
      if (k <= 3) begin
        if (s_add_a !== 32'h4100_0000 || s_add_b !== 32'h3F80_0000 || s_resp0_valid !== 1'b0 || s_busy !== 1'b1) begin
          errors++;
          $display("FAIL lat3_wait%0d: add_a=%h add_b=%h rv0=%b busy=%b, required 41000000 3f800000 0 1",
                   k, s_add_a, s_add_b, s_resp0_valid, s_busy);
        end
      end else if (s_resp0_valid !== 1'b1 || s_resp0_data !== 32'h4120_0030) begin
        errors++;
        $display("FAIL lat3_resp: rv0=%b data=%h, required 1 41200030", s_resp0_valid, s_resp0_data);
      end
    end
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_resp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat3_done: busy=%b rv0=%b, required 0 0", s_busy, s_resp0_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    s_req1_a = 32'h3F80_0000; s_req1_b = 32'h3F80_0000; s_req1_valid = 1'b1; s_resp1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_accept: s_req1_ready=%b, required 1", s_req1_ready);
    end
    @(posedge clk); #1;
    s_req1_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_resp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_in_reset: busy=%b rv1=%b, required 0 0", s_busy, s_resp1_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    s_req0_a = 32'h3F80_0000; s_req0_b = 32'h3F80_0000;
    s_req0_valid = 1'b1; s_req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_resp0_valid !== 1'b0 || s_resp1_valid !== 1'b0 || s_add_a !== 32'd0 || s_add_b !== 32'd0) begin
      errors++;
      $display("FAIL rmid_idle: busy=%b rv0=%b rv1=%b add_a=%h add_b=%h, required 0 0 0 0 0",
               s_busy, s_resp0_valid, s_resp1_valid, s_add_a, s_add_b);
    end
    checks++;
    if (s_req0_ready !== 1'b1 || s_req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_tie: rdy0=%b rdy1=%b, required 1 0", s_req0_ready, s_req1_ready);
    end
    @(posedge clk); #1;
    s_req0_valid = 1'b0; s_req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (s_resp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_ghost_resp: rv1=%b at cycle %0d, required 0", s_resp1_valid, i);
      end
    end
  endtask

  initial begin
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    s_req0_a = '0; s_req0_b = '0; s_req1_a = '0; s_req1_b = '0; s_add_out = '0;
    s_resp0_ready = 1'b0; s_resp1_ready = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_add_lat3();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
